// File: rtl/grant_sequencer_8.sv
// Round-robin arbiter for eight requesters with hold watchdog
// and a break-before-make gap between consecutive grants.
module grant_sequencer_8 #(
  parameter int MAX_HOLD   = 200,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic [2:0] grant_code,
  output logic       timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam bit         WD_EN     = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST =
    8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

  logic [1:0]  state;
  logic [2:0]  ptr;
  logic [7:0]  hcnt;
  logic [3:0]  gcnt;

  logic [15:0] req2;
  logic [7:0]  rot;
  logic [2:0]  off;
  logic [2:0]  pick;
  logic        hit;
  logic        expire;
  logic        rel;

  // Rotate req so ptr lands on bit 0, then take the lowest set bit.
  always_comb begin
    req2 = {req, req};
    rot  = req2[ptr +: 8];
    off  = 3'd0;
    hit  = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (rot[k]) begin
        off = 3'(k);
        hit = 1'b1;
      end
    end
    pick = ptr + off;
  end

  assign expire = WD_EN && (hcnt == HOLD_LAST);
  assign rel    = done || !req[grant_idx] || expire;

  // Sequencer: arbitrate in IDLE, hold in GRANT, dwell in GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= 3'd0;
      hcnt        <= 8'd0;
      gcnt        <= 4'd0;
      grant_valid <= 1'b0;
      grant_idx   <= 3'd0;
      grant_code  <= 3'b111;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (hit) begin
            grant_idx   <= pick;
            grant_code  <= ~pick;
            grant_valid <= 1'b1;
            ptr         <= pick + 3'd1;
            hcnt        <= 8'd0;
            state       <= S_GRANT;
          end
        end
        (state == S_GRANT): begin
          if (hcnt != 8'hFF) hcnt <= hcnt + 8'd1;
          if (rel) begin
            grant_valid <= 1'b0;
            gcnt        <= GAP_LOAD;
            timeout     <= !done && req[grant_idx];
            state       <= S_GAP;
          end
        end
        (state == S_GAP): begin
          if (gcnt == 4'd0) state <= S_IDLE;
          else gcnt <= gcnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
